btn_debounce: RTL and testbench

Single-input push-button/switch debouncer that sits directly downstream of the clock divider. It consumes the divider's one-cycle `tick` enable as its sampling strobe. The raw asynchronous input is synchronised, then qualified by a four-state FSM that requires `STABLE_TICKS` consecutive tick samples before accepting a new level. Outputs are the debounced level plus one-cycle rise and fall pulses for FSMs and counters elsewhere in the design.

---
 rtl/btn_debounce.sv | 130 +++++++++++++
 tb/tb_btn_debounce.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce
//   Single-input push-button/switch debouncer. The raw input is passed
//   through a two-flop synchroniser, then qualified by a four-state FSM that
//   only accepts a new level after STABLE_TICKS consecutive `tick` samples
//   at that level. Any return to the old level while waiting aborts the
//   qualification without producing a pulse.
//
// Parameters
//   STABLE_TICKS : counted ticks needed to accept a change (1..255)
//
// Ports
//   clk_in   in  : system clock, rising edge
//   reset    in  : synchronous, active-high
//   tick     in  : one-cycle sampling strobe from the clock divider
//   sw_in    in  : raw button/switch, asynchronous to clk_in
//   db_level out : debounced level (registered)
//   db_rise  out : one-cycle pulse on db_level 0->1 (registered)
//   db_fall  out : one-cycle pulse on db_level 1->0 (registered)
module btn_debounce #(
    parameter int STABLE_TICKS = 3
) (
    input  logic clk_in,
    input  logic reset,
    input  logic tick,
    input  logic sw_in,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    // Terminal count: the tick that arrives while cnt equals this value is
    // the STABLE_TICKS-th one, so cnt never goes beyond it.
    localparam logic [7:0] CNT_LAST = 8'(STABLE_TICKS - 1);

    logic   s1;
    logic   sw_sync;
    state_t state;
    state_t state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic   rise_nxt;
    logic   fall_nxt;

    // Synchroniser stage: sw_in -> s1 -> sw_sync
    always_ff @(posedge clk_in) begin
        if (reset) begin
            s1      <= 1'b0;
            sw_sync <= 1'b0;
        end else begin
            s1      <= sw_in;
            sw_sync <= s1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ZERO: begin
                if (sw_sync) begin
                    state_nxt = WAIT1;
                    cnt_nxt   = 8'd0;
                end
            end
            WAIT1: begin
                // A bounce back low aborts immediately, tick or not.
                if (!sw_sync) begin
                    state_nxt = ZERO;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = ONE;
                        rise_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            ONE: begin
                if (!sw_sync) begin
                    state_nxt = WAIT0;
                    cnt_nxt   = 8'd0;
                end
            end
            WAIT0: begin
                if (sw_sync) begin
                    state_nxt = ONE;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = ZERO;
                        fall_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = ZERO;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // FSM / output register stage. db_level follows the next state so that
    // it changes on the same edge as the corresponding pulse.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= ZERO;
            cnt      <= 8'd0;
            db_level <= 1'b0;
            db_rise  <= 1'b0;
            db_fall  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            db_level <= (state_nxt == ONE) || (state_nxt == WAIT0);
            db_rise  <= rise_nxt;
            db_fall  <= fall_nxt;
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    logic tick_a = 1'b0;
    logic tick_b = 1'b1;
    logic sw_in  = 1'b0;
    logic lvl_a, rise_a, fall_a;
    logic lvl_b, rise_b, fall_b;

    always #5 clk_in = ~clk_in;

    btn_debounce #(.STABLE_TICKS(3)) dut_a (
        .clk_in   (clk_in),
        .reset    (reset),
        .tick     (tick_a),
        .sw_in    (sw_in),
        .db_level (lvl_a),
        .db_rise  (rise_a),
        .db_fall  (fall_a)
    );

    btn_debounce #(.STABLE_TICKS(1)) dut_b (
        .clk_in   (clk_in),
        .reset    (reset),
        .tick     (tick_b),
        .sw_in    (sw_in),
        .db_level (lvl_b),
        .db_rise  (rise_b),
        .db_fall  (fall_b)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int free_cnt = 0;
    int tick_mode = 0;
    int n_rise_a = 0;
    int n_fall_a = 0;

    // Reference model: the synchronised input is the raw input delayed two
    // edges. A level change is accepted once the synchronised input has
    // disagreed with the current level continuously and, after the edge on
    // which the disagreement was first noticed, N ticks have been sampled.
    bit m_dly[2];
    bit m_lvl[2];
    bit m_run[2];
    bit m_rise[2];
    bit m_fall[2];
    int m_tks[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        int  n;
        bit  t;
        bit  seen;
        seen = m_dly[1];
        for (int i = 0; i < 2; i++) begin
            n = (i == 0) ? 3 : 1;
            t = (i == 0) ? tick_a : tick_b;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (reset) begin
                m_lvl[i] = 1'b0;
                m_run[i] = 1'b0;
                m_tks[i] = 0;
            end else if (seen == m_lvl[i]) begin
                m_run[i] = 1'b0;
                m_tks[i] = 0;
            end else if (!m_run[i]) begin
                m_run[i] = 1'b1;
                m_tks[i] = 0;
            end else if (t) begin
                m_tks[i]++;
                if (m_tks[i] == n) begin
                    m_lvl[i]  = ~m_lvl[i];
                    m_rise[i] = m_lvl[i];
                    m_fall[i] = ~m_lvl[i];
                    m_run[i]  = 1'b0;
                    m_tks[i]  = 0;
                end
            end
        end
        if (reset) begin
            m_dly[0] = 1'b0;
            m_dly[1] = 1'b0;
        end else begin
            m_dly[1] = m_dly[0];
            m_dly[0] = sw_in;
        end
    endtask

    // Called at a falling edge with sw_in/reset already set for the next edge.
    task automatic step();
        free_cnt++;
        if (tick_mode == 0) begin
            tick_a = (free_cnt % 10 == 0);
            tick_b = 1'b1;
        end else begin
            tick_a = ($urandom_range(3) == 0);
            tick_b = ($urandom_range(1) == 0);
        end
        model_edge();
        @(posedge clk_in);
        cyc++;
        @(negedge clk_in);
        check("a_level", lvl_a,  m_lvl[0]);
        check("a_rise",  rise_a, m_rise[0]);
        check("a_fall",  fall_a, m_fall[0]);
        check("b_level", lvl_b,  m_lvl[1]);
        check("b_rise",  rise_b, m_rise[1]);
        check("b_fall",  fall_b, m_fall[1]);
        if (rise_a) n_rise_a++;
        if (fall_a) n_fall_a++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int  rise_cyc_b;
        bit  found;
        int  run_len;

        @(negedge clk_in);
        do_reset(2);

        // Idle after reset with the input low.
        n_rise_a = 0;
        n_fall_a = 0;
        repeat (50) step();
        check("idle_rises_a", n_rise_a, 0);
        check("idle_falls_a", n_fall_a, 0);

        // Clean press: N=1 with tick held high must rise on cycle 14.
        do_reset(1);
        n_rise_a = 0;
        repeat (10) step();
        sw_in = 1'b1;
        rise_cyc_b = -1;
        repeat (60) begin
            step();
            if (rise_b && rise_cyc_b < 0) rise_cyc_b = cyc;
        end
        check("b_rise_cycle", rise_cyc_b, 14);
        check("press_rises_a", n_rise_a, 1);
        check("press_level_a", lvl_a, 1);

        // Bounce 4 low / 4 high: no low stretch can span three ticks.
        n_fall_a = 0;
        for (int k = 0; k < 60; k++) begin
            sw_in = ((k / 4) % 2) != 0;
            step();
        end
        sw_in = 1'b1;
        repeat (4) step();
        check("bounce_falls_a", n_fall_a, 0);
        check("bounce_level_a", lvl_a, 1);

        // Clean release.
        n_fall_a = 0;
        sw_in = 1'b0;
        repeat (60) step();
        check("release_falls_a", n_fall_a, 1);
        check("release_level_a", lvl_a, 0);

        // Reset while waiting to rise with two ticks already counted.
        sw_in = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (m_run[0] && !m_lvl[0] && m_tks[0] == 2) found = 1'b1;
        end
        check("wait1_cnt2_reached", found, 1);
        reset = 1'b1;
        step();
        check("rst_level_a", lvl_a, 0);
        check("rst_rise_a", rise_a, 0);
        reset = 1'b0;
        n_rise_a = 0;
        repeat (60) step();
        check("requal_rises_a", n_rise_a, 1);
        check("requal_level_a", lvl_a, 1);

        // Randomised runs of input level, random ticks, occasional reset.
        tick_mode = 1;
        run_len = 0;
        repeat (3000) begin
            if (run_len == 0) begin
                sw_in = ~sw_in;
                run_len = ($urandom_range(3) == 0) ? $urandom_range(60, 15) : $urandom_range(6, 1);
            end
            run_len--;
            reset = ($urandom_range(399) == 0);
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout at cycle %0d: simulation did not finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
